// File: rtl/alu_seq.sv
// alu_seq: accumulator ALU on a shared tri-state bus.
// Single-cycle ops finish at the capture edge. SHL and MUL run
// bit-serially in a working register. AREG and the flags change only
// when an operation completes.
module alu_seq #(
  parameter int W  = 8,
  parameter int BW = 16
) (
  input  logic          CLK,
  input  logic          AR,
  input  logic          AOE,
  input  logic          ALE,
  input  logic [2:0]    ALS,
  inout  wire  [BW-1:0] DATA,
  output logic          BUSY,
  output logic          DONE,
  output logic          CF,
  output logic          ZF,
  output logic          NF,
  output logic          VF
);

  localparam int KW = $clog2(W);
  // Wide enough for both W (multiply steps) and the largest shift count
  localparam int CW = KW + 1;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  state_t          state_r, state_nx;
  logic [W-1:0]    areg_r, areg_nx;
  logic            cf_r, cf_nx, zf_r, zf_nx, nf_r, nf_nx, vf_r, vf_nx;
  logic            busy_r, busy_nx, done_r, done_nx;
  // work_r holds the shifting value (SHIFT) or the multiplicand (MUL)
  logic [W-1:0]    work_r, work_nx;
  // prod_r is {partial high half, remaining multiplier bits}
  logic [2*W-1:0]  prod_r, prod_nx;
  logic [CW-1:0]   cnt_r, cnt_nx;

  logic [W-1:0]    b_s;
  logic [KW-1:0]   shamt_s;
  logic [W:0]      sum_s;
  logic [W:0]      dif_s;
  logic [W:0]      mul_add_s;
  logic [2*W-1:0]  mul_step_s;
  logic [W-1:0]    shl_step_s;
  logic            commit_s;
  logic [W-1:0]    res_s;
  logic            rcf_s;
  logic            rvf_s;
  logic            unused_s;

  assign b_s        = DATA[W-1:0];
  assign shamt_s    = b_s[KW-1:0];
  assign sum_s      = {1'b0, areg_r} + {1'b0, b_s};
  assign dif_s      = {1'b0, areg_r} - {1'b0, b_s};
  assign mul_add_s  = {1'b0, prod_r[2*W-1:W]} + ({1'b0, work_r} & {(W+1){prod_r[0]}});
  assign mul_step_s = {mul_add_s, prod_r[W-1:1]};
  assign shl_step_s = {work_r[W-2:0], 1'b0};
  // Upper bus bits are only ever driven, never consumed
  assign unused_s   = ^DATA;

  // The bus driver depends on AOE alone, so it shows the pre-operation AREG while busy
  assign DATA = AOE ? BW'(areg_r) : {BW{1'bz}};

  assign BUSY = busy_r;
  assign DONE = done_r;
  assign CF   = cf_r;
  assign ZF   = zf_r;
  assign NF   = nf_r;
  assign VF   = vf_r;

  // Next-state, datapath step and completion/flag logic
  always_comb begin
    state_nx = state_r;
    areg_nx  = areg_r;
    cf_nx    = cf_r;
    zf_nx    = zf_r;
    nf_nx    = nf_r;
    vf_nx    = vf_r;
    work_nx  = work_r;
    prod_nx  = prod_r;
    cnt_nx   = cnt_r;
    busy_nx  = busy_r;
    done_nx  = 1'b0;
    commit_s = 1'b0;
    res_s    = areg_r;
    rcf_s    = 1'b0;
    rvf_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ALE) begin
          case (ALS)
            OP_LOAD: begin
              commit_s = 1'b1;
              res_s    = b_s;
            end
            OP_ADD: begin
              commit_s = 1'b1;
              res_s    = sum_s[W-1:0];
              rcf_s    = sum_s[W];
              rvf_s    = (areg_r[W-1] == b_s[W-1]) && (sum_s[W-1] != areg_r[W-1]);
            end
            OP_SUB: begin
              commit_s = 1'b1;
              res_s    = dif_s[W-1:0];
              rcf_s    = dif_s[W];
              rvf_s    = (areg_r[W-1] != b_s[W-1]) && (dif_s[W-1] != areg_r[W-1]);
            end
            OP_AND: begin
              commit_s = 1'b1;
              res_s    = areg_r & b_s;
            end
            OP_OR: begin
              commit_s = 1'b1;
              res_s    = areg_r | b_s;
            end
            OP_XOR: begin
              commit_s = 1'b1;
              res_s    = areg_r ^ b_s;
            end
            OP_SHL: begin
              if (shamt_s == KW'(0)) begin
                commit_s = 1'b1;
                res_s    = areg_r;
              end else begin
                state_nx = ST_SHIFT;
                work_nx  = areg_r;
                cnt_nx   = CW'(shamt_s);
                busy_nx  = 1'b1;
              end
            end
            OP_MUL: begin
              state_nx = ST_MUL;
              work_nx  = areg_r;
              prod_nx  = {{W{1'b0}}, b_s};
              cnt_nx   = CW'(W);
              busy_nx  = 1'b1;
            end
            default: begin
              commit_s = 1'b0;
            end
          endcase
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_nx = shl_step_s;
        cnt_nx  = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          commit_s = 1'b1;
          res_s    = shl_step_s;
          rcf_s    = work_r[W-1];
        end else begin
          commit_s = 1'b0;
        end
      end
      ST_MUL: begin
        prod_nx = mul_step_s;
        cnt_nx  = cnt_r - CW'(1);
        if (cnt_r == CW'(1)) begin
          commit_s = 1'b1;
          res_s    = mul_step_s[W-1:0];
          rcf_s    = |mul_step_s[2*W-1:W];
          rvf_s    = |mul_step_s[2*W-1:W];
        end else begin
          commit_s = 1'b0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        busy_nx  = 1'b0;
      end
    endcase
    if (commit_s) begin
      areg_nx  = res_s;
      cf_nx    = rcf_s;
      zf_nx    = (res_s == W'(0));
      nf_nx    = res_s[W-1];
      vf_nx    = rvf_s;
      done_nx  = 1'b1;
      busy_nx  = 1'b0;
      state_nx = ST_IDLE;
    end else begin
      done_nx  = 1'b0;
    end
  end

  // State and datapath registers; AR low clears everything and aborts any operation
  always_ff @(posedge CLK) begin
    if (!AR) begin
      state_r <= ST_IDLE;
      areg_r  <= '0;
      cf_r    <= 1'b0;
      zf_r    <= 1'b0;
      nf_r    <= 1'b0;
      vf_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      work_r  <= '0;
      prod_r  <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nx;
      areg_r  <= areg_nx;
      cf_r    <= cf_nx;
      zf_r    <= zf_nx;
      nf_r    <= nf_nx;
      vf_r    <= vf_nx;
      busy_r  <= busy_nx;
      done_r  <= done_nx;
      work_r  <= work_nx;
      prod_r  <= prod_nx;
      cnt_r   <= cnt_nx;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (W=8, BW=16).
// Expected results are pushed into a queue when an operation is issued.
// A monitor pops one entry on every DONE pulse and compares AREG (read
// over DATA), the flags and the number of BUSY cycles.
module tb_alu_seq;

  localparam logic [2:0] LOAD = 3'b000;
  localparam logic [2:0] ADD  = 3'b001;
  localparam logic [2:0] SUB  = 3'b010;
  localparam logic [2:0] ANDO = 3'b011;
  localparam logic [2:0] ORO  = 3'b100;
  localparam logic [2:0] XORO = 3'b101;
  localparam logic [2:0] SHL  = 3'b110;
  localparam logic [2:0] MUL  = 3'b111;

  logic        CLK = 1'b0;
  logic        AR;
  logic        AOE;
  logic        ALE;
  logic [2:0]  ALS;
  wire  [15:0] DATA;
  logic        BUSY, DONE, CF, ZF, NF, VF;
  logic        drv_en;
  logic [15:0] drv_val;

  assign DATA = drv_en ? drv_val : 16'hzzzz;

  alu_seq #(.W(8), .BW(16)) dut (
    .CLK(CLK), .AR(AR), .AOE(AOE), .ALE(ALE), .ALS(ALS), .DATA(DATA),
    .BUSY(BUSY), .DONE(DONE), .CF(CF), .ZF(ZF), .NF(NF), .VF(VF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] areg;
    logic [3:0] flags;   // {CF, ZF, NF, VF}
    int         busy;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  int   op_id    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: count BUSY cycles and score each DONE pulse against the queue
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (!AR) begin
      busy_cnt = 0;
    end else begin
      if (BUSY) busy_cnt++;
      if (DONE) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(DONE), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("op%0d_areg", e.id), 32'(DATA), 32'(e.areg));
          chk($sformatf("op%0d_flags_cznv", e.id), 32'({CF, ZF, NF, VF}), 32'(e.flags));
          chk($sformatf("op%0d_busy_cycles", e.id), 32'(busy_cnt), 32'(e.busy));
        end
        busy_cnt = 0;
        done_cnt++;
      end
    end
  end

  task automatic expect_res(input logic [7:0] areg, input logic [3:0] flags, input int busy);
    exp_t e;
    op_id++;
    e.areg  = areg;
    e.flags = flags;
    e.busy  = busy;
    e.id    = op_id;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] b, input bit self_op);
    @(negedge CLK);
    ALE = 1'b1;
    ALS = op;
    if (self_op) begin
      AOE    = 1'b1;
      drv_en = 1'b0;
    end else begin
      AOE     = 1'b0;
      drv_val = {8'h00, b};
      drv_en  = 1'b1;
    end
    @(posedge CLK);
    #1;
    ALE    = 1'b0;
    drv_en = 1'b0;
    AOE    = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge CLK);
      if (done_cnt != start) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("op%0d_done_seen", op_id), 32'(got), 32'd1);
  endtask

  task automatic run(input logic [2:0] op, input logic [7:0] b, input logic [7:0] areg,
                     input logic [3:0] flags, input int busy);
    expect_res(areg, flags, busy);
    issue(op, b, 1'b0);
    wait_done(20);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int saved;
    // Reset with a LOAD strobe held at the same edges: reset must win
    AR = 1'b0; AOE = 1'b0; ALE = 1'b1; ALS = LOAD;
    drv_val = 16'h0077; drv_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    ALE = 1'b0; drv_en = 1'b0; AOE = 1'b1;
    #1;
    chk("reset_data", 32'(DATA), 32'h0000);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    chk("reset_flags", 32'({CF, ZF, NF, VF}), 32'd0);
    AR = 1'b1;
    @(negedge CLK);
    chk("post_reset_no_done", 32'(DONE), 32'd0);
    chk("post_reset_data", 32'(DATA), 32'h0000);

    //          op    B      AREG   CZNV     busy
    run(LOAD, 8'h7F, 8'h7F, 4'b0000, 0);
    run(ADD,  8'h01, 8'h80, 4'b0011, 0);
    run(SUB,  8'h80, 8'h00, 4'b0100, 0);
    run(SUB,  8'h01, 8'hFF, 4'b1010, 0);
    run(LOAD, 8'h81, 8'h81, 4'b0010, 0);
    run(SHL,  8'h03, 8'h08, 4'b0000, 3);
    run(SHL,  8'h00, 8'h08, 4'b0000, 0);
    run(LOAD, 8'hC1, 8'hC1, 4'b0010, 0);
    run(SHL,  8'h01, 8'h82, 4'b1010, 1);
    run(SHL,  8'h00, 8'h82, 4'b0010, 0);
    run(SHL,  8'h0B, 8'h10, 4'b0000, 3);

    // MUL 0x10*0x10 with a LOAD strobe during BUSY that must be ignored
    expect_res(8'h00, 4'b1101, 8);
    issue(MUL, 8'h10, 1'b0);
    repeat (2) @(posedge CLK);
    issue(LOAD, 8'h55, 1'b0);
    wait_done(20);

    run(LOAD, 8'h0C, 8'h0C, 4'b0000, 0);
    // MUL 0x0C*0x0B = 0x84; the bus shows the old AREG while busy
    expect_res(8'h84, 4'b0010, 8);
    issue(MUL, 8'h0B, 1'b0);
    @(negedge CLK);
    chk("mul_busy_high", 32'(BUSY), 32'd1);
    chk("mul_busy_data", 32'(DATA), 32'h000C);
    wait_done(20);

    run(LOAD, 8'hF0, 8'hF0, 4'b0010, 0);
    run(ANDO, 8'h3C, 8'h30, 4'b0000, 0);
    run(ORO,  8'h0F, 8'h3F, 4'b0000, 0);
    run(XORO, 8'hFF, 8'hC0, 4'b0010, 0);
    run(SUB,  8'h7F, 8'h41, 4'b0001, 0);

    // Abort a MUL by reset during its fourth BUSY cycle
    run(LOAD, 8'h03, 8'h03, 4'b0000, 0);
    issue(MUL, 8'h05, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    AR = 1'b0;
    @(posedge CLK);
    #1;
    AR = 1'b1;
    @(negedge CLK);
    chk("abort_areg", 32'(DATA), 32'h0000);
    chk("abort_flags", 32'({CF, ZF, NF, VF}), 32'd0);
    chk("abort_busy", 32'(BUSY), 32'd0);
    chk("abort_done", 32'(DONE), 32'd0);
    saved = done_cnt;
    repeat (12) @(posedge CLK);
    chk("abort_no_done", 32'(done_cnt), 32'(saved));

    // Bus drive/release and a self-operand ADD
    run(LOAD, 8'hAB, 8'hAB, 4'b0010, 0);
    @(negedge CLK);
    AOE = 1'b1;
    #1;
    chk("bus_driven", 32'(DATA), 32'h00AB);
    AOE = 1'b0; drv_val = 16'h5454; drv_en = 1'b1;
    #1;
    chk("bus_released", 32'(DATA), 32'h5454);
    drv_en = 1'b0; AOE = 1'b1;
    expect_res(8'h56, 4'b1001, 0);
    issue(ADD, 8'h00, 1'b1);
    wait_done(20);

    repeat (2) @(posedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
